hbridge_pwm_driver: RTL and testbench
=====================================

// Module: hbridge_pwm_driver
// PURPOSE
//   Downstream stage of the line-following motor decision logic. Consumes the per-motor
//   direction code (motorIn) and enable (motorEn) and drives two H-bridge channels.
//   Each channel gets a PWM enable with a soft-start duty ramp. A dead-time brake window
//   is inserted on every direction reversal so the bridge never switches straight from
//   forward to reverse.
// PARAMETERS
//   PWM_BITS   8     PWM counter width; period = 2**PWM_BITS - 1 clocks
//   DUTY_MAX   200   final duty (counts of period), must be <= 2**PWM_BITS - 1
//   RAMP_STEP  8     duty increment per ramp tick
//   RAMP_DIV   1024  clocks between ramp ticks
//   DEADTIME   256   clocks of brake (pins 00, enable low) on reversal
// PORTS
//   clk        in   1  system clock
//   rst        in   1  asynchronous, active-high reset
//   motorIn    in   4  [3:2] left dir, [1:0] right dir; 2'b10 fwd, 2'b01 rev, 00/11 stop
//   motorEn    in   2  [1] left on, [0] right on
//   hbIn       out  4  bridge direction pins, same bit mapping as motorIn
//   hbEn       out  2  PWM enable per bridge
//   settled    out  2  channel in RUN with duty == DUTY_MAX
//   deadActive out  2  channel currently in dead-time window
// BEHAVIOUR
//   Reset (async assert, sync release): all outputs 0; duty 0; state IDLE; PWM counter 0.
//   Inputs are registered once. All outputs are registered. A change on an input is visible
//   on outputs at the 2nd rising edge after it.
//   PWM: shared counter 0..2**PWM_BITS-2, wraps to 0.
//     hbEn[c] = (state==RUN) && (cnt < duty_active[c]).
//     duty_active loads from the ramp duty only at cnt wrap, so there are no mid-period glitches.
//   Ramp: shared tick divider, 1-clk pulse every RAMP_DIV clocks. On a tick in RUN,
//     duty = min(duty+RAMP_STEP, DUTY_MAX). Saturate, never wrap. Use PWM_BITS+1 bits for the add.
//   Per-channel FSM (dir = 2-bit code, valid = 10 or 01, en = motorEn bit):
//     IDLE : pins 00, duty 0.
//            -> RUN when en && valid dir; latch dir.
//     RUN  : pins = latched dir, ramp active.
//            -> IDLE when !en or dir invalid; duty cleared immediately.
//            -> DEAD when dir valid and != latched dir; pins 00, duty 0, dead counter = DEADTIME-1.
//     DEAD : pins 00, hbEn 0, counter decrements each clock.
//            -> IDLE when !en or dir invalid, even mid-window.
//            -> new reversal back to the old dir restarts the counter with the new dir latched.
//            -> RUN at counter 0 with the dir now present; duty restarts from 0.
//   Simultaneous events: !en has priority over any direction change.
//     Both channels are fully independent except for the shared PWM counter and ramp tick.
//   The same dir re-asserted while in RUN is no event; the ramp continues.
//   The instant stop when !en bypasses the ramp-down; this is a safety requirement.
//   hbIn is never 2'b11. hbIn changes only while hbEn for that channel is 0 or in the
//     same registered cycle hbEn drops.
//   Reset mid-DEAD or mid-ramp: immediate return to reset values.
// STRUCTURE
//   Package hbridge_pkg: channel state enum {IDLE,RUN,DEAD}, DIR_FWD=2'b10, DIR_REV=2'b01,
//     function dir_valid().
//   Top: input registers, shared PWM counter, shared ramp divider, 2x sub-module.
//   Sub-module hbridge_channel: per-channel FSM, dead counter, ramp duty, duty_active, output regs.
// TESTING
//   1 Reset hold 10 clks -> hbIn=0, hbEn=0, settled=0, deadActive=0; release -> unchanged.
//   2 motorEn=11, motorIn=1010 -> hbIn=1010 after 2 clks.
//     Duty ramps 8,16..200 over 25 ticks; settled=11.
//     hbEn high 200 of 255 clks.
//   3 In settled RUN, motorIn 1010->0110 -> left hbIn=00, hbEn=0, deadActive=10 for 256 clks.
//     Then hbIn=0110, left duty restarts at 0. Right channel is unaffected throughout.
//   4 Mid-ramp motorEn 11->01 -> left hbEn=0, hbIn[3:2]=00 on 2nd edge. Re-enable -> duty from 0.
//   5 motorIn[1:0]=11 in RUN -> right channel IDLE, pins 00. No illegal 11 ever on hbIn.
//   6 Assert rst mid-DEAD (counter ~100) -> outputs 0 asynchronously.
//     After release with same inputs -> RUN from duty 0, no dead window.

Source files
------------

// File: rtl/hbridge_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hbridge_pkg : shared types and direction codes for the H-bridge    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package hbridge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DEAD = 2'd2
   } ch_state_t;

   localparam logic [1:0] DIR_FWD  = 2'b10;
   localparam logic [1:0] DIR_REV  = 2'b01;
   localparam logic [1:0] DIR_STOP = 2'b00;

   function automatic logic dir_valid(input logic [1:0] dir);
      return (dir == DIR_FWD) || (dir == DIR_REV);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hbridge_channel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hbridge_channel : one bridge - FSM, dead-time, soft-start duty     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module hbridge_channel
   import hbridge_pkg::*;
#(
   parameter int PWM_BITS  = 8,
   parameter int DUTY_MAX  = 200,
   parameter int RAMP_STEP = 8,
   parameter int DEADTIME  = 256
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          i_dir,
   input  logic                i_en,
   input  logic [PWM_BITS-1:0] i_cnt_nx,
   input  logic                i_wrap,
   input  logic                i_tick,
   output logic [1:0]          o_hb_in,
   output logic                o_hb_en,
   output logic                o_settled,
   output logic                o_dead_active
);

   localparam int DEAD_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
   localparam logic [PWM_BITS:0]   c_step         = (PWM_BITS+1)'(RAMP_STEP);
   localparam logic [PWM_BITS:0]   c_duty_max_ext = (PWM_BITS+1)'(DUTY_MAX);
   localparam logic [PWM_BITS-1:0] c_duty_max     = PWM_BITS'(DUTY_MAX);
   localparam logic [DEAD_W-1:0]   c_dead_load    = DEAD_W'(DEADTIME-1);

   ch_state_t           r_state, w_state_nx;
   logic [1:0]          r_dir, w_dir_nx;
   logic [DEAD_W-1:0]   r_dead_cnt, w_dead_nx;
   logic [PWM_BITS-1:0] r_duty, w_duty_nx;
   logic [PWM_BITS-1:0] r_duty_act, w_duty_act_nx;
   logic [PWM_BITS:0]   w_sum;
   logic [1:0]          w_hb_in_nx;
   logic                w_hb_en_nx, w_settled_nx, w_dead_active_nx;
   logic                w_ok;

   assign w_sum = {1'b0, r_duty} + c_step;
   assign w_ok  = i_en && dir_valid(i_dir);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_dir         <= DIR_STOP;
         r_dead_cnt    <= '0;
         r_duty        <= '0;
         r_duty_act    <= '0;
         o_hb_in       <= DIR_STOP;
         o_hb_en       <= 1'b0;
         o_settled     <= 1'b0;
         o_dead_active <= 1'b0;
      end else begin
         r_state       <= w_state_nx;
         r_dir         <= w_dir_nx;
         r_dead_cnt    <= w_dead_nx;
         r_duty        <= w_duty_nx;
         r_duty_act    <= w_duty_act_nx;
         o_hb_in       <= w_hb_in_nx;
         o_hb_en       <= w_hb_en_nx;
         o_settled     <= w_settled_nx;
         o_dead_active <= w_dead_active_nx;
      end
   end

   // Loss of enable or an invalid code is checked first so it wins over reversals.
   always_comb begin
      w_state_nx = r_state;
      w_dir_nx   = r_dir;
      w_dead_nx  = r_dead_cnt;
      w_duty_nx  = '0;
      case (r_state)
         IDLE: begin
            if (w_ok) begin
               w_state_nx = RUN;
               w_dir_nx   = i_dir;
            end
         end
         RUN: begin
            if (!w_ok) begin
               w_state_nx = IDLE;
            end else if (i_dir != r_dir) begin
               w_state_nx = DEAD;
               w_dir_nx   = i_dir;
               w_dead_nx  = c_dead_load;
            end else if (i_tick) begin
               w_duty_nx = (w_sum > c_duty_max_ext) ? c_duty_max : w_sum[PWM_BITS-1:0];
            end else begin
               w_duty_nx = r_duty;
            end
         end
         DEAD: begin
            if (!w_ok) begin
               w_state_nx = IDLE;
            end else if (i_dir != r_dir) begin
               w_dir_nx  = i_dir;
               w_dead_nx = c_dead_load;
            end else if (r_dead_cnt == '0) begin
               w_state_nx = RUN;
            end else begin
               w_dead_nx = r_dead_cnt - DEAD_W'(1);
            end
         end
         default: w_state_nx = IDLE;
      endcase
      // Active duty only changes on a period boundary; outside RUN it is forced to zero.
      if (w_state_nx != RUN)
         w_duty_act_nx = '0;
      else if (i_wrap)
         w_duty_act_nx = w_duty_nx;
      else
         w_duty_act_nx = r_duty_act;
   end

   always_comb begin
      w_hb_in_nx       = DIR_STOP;
      w_hb_en_nx       = 1'b0;
      w_settled_nx     = 1'b0;
      w_dead_active_nx = (w_state_nx == DEAD);
      if (w_state_nx == RUN) begin
         w_hb_in_nx   = w_dir_nx;
         w_hb_en_nx   = (i_cnt_nx < w_duty_act_nx);
         w_settled_nx = (w_duty_nx == c_duty_max);
      end
   end

endmodule
`default_nettype wire

// File: rtl/hbridge_pwm_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hbridge_pwm_driver : two-channel H-bridge driver, PWM + dead-time  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module hbridge_pwm_driver
   import hbridge_pkg::*;
#(
   parameter int PWM_BITS  = 8,
   parameter int DUTY_MAX  = 200,
   parameter int RAMP_STEP = 8,
   parameter int RAMP_DIV  = 1024,
   parameter int DEADTIME  = 256
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] motorIn,
   input  logic [1:0] motorEn,
   output logic [3:0] hbIn,
   output logic [1:0] hbEn,
   output logic [1:0] settled,
   output logic [1:0] deadActive
);

   localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [PWM_BITS-1:0] c_cnt_max = PWM_BITS'(2**PWM_BITS - 2);
   localparam logic [DIV_W-1:0]    c_div_max = DIV_W'(RAMP_DIV - 1);

   logic [3:0]          r_motor_in;
   logic [1:0]          r_motor_en;
   logic [PWM_BITS-1:0] r_cnt, w_cnt_nx;
   logic [DIV_W-1:0]    r_div;
   logic                w_wrap, w_tick;

   assign w_wrap   = (r_cnt == c_cnt_max);
   assign w_cnt_nx = w_wrap ? '0 : r_cnt + PWM_BITS'(1);
   assign w_tick   = (r_div == c_div_max);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_motor_in <= '0;
         r_motor_en <= '0;
         r_cnt      <= '0;
         r_div      <= '0;
      end else begin
         r_motor_in <= motorIn;
         r_motor_en <= motorEn;
         r_cnt      <= w_cnt_nx;
         r_div      <= w_tick ? '0 : r_div + DIV_W'(1);
      end
   end

   // Index 0 is the right motor (bits [1:0]), index 1 the left (bits [3:2]).
   for (genvar gi = 0; gi < 2; gi++) begin : g_channel
      hbridge_channel #(
         .PWM_BITS  (PWM_BITS),
         .DUTY_MAX  (DUTY_MAX),
         .RAMP_STEP (RAMP_STEP),
         .DEADTIME  (DEADTIME)
      ) u_channel (
         .clk           (clk),
         .rst           (rst),
         .i_dir         (r_motor_in[2*gi +: 2]),
         .i_en          (r_motor_en[gi]),
         .i_cnt_nx      (w_cnt_nx),
         .i_wrap        (w_wrap),
         .i_tick        (w_tick),
         .o_hb_in       (hbIn[2*gi +: 2]),
         .o_hb_en       (hbEn[gi]),
         .o_settled     (settled[gi]),
         .o_dead_active (deadActive[gi])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_hbridge_pwm_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_hbridge_pwm_driver : directed bench with a cycle-level model    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_hbridge_pwm_driver;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DEAD = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] motorIn;
   logic [1:0] motorEn;
   logic [3:0] hbIn;
   logic [1:0] hbEn;
   logic [1:0] settled;
   logic [1:0] deadActive;

   int tests = 0;
   int fails = 0;
   int ill   = 0;

   hbridge_pwm_driver dut (
      .clk        (clk),
      .rst        (rst),
      .motorIn    (motorIn),
      .motorEn    (motorEn),
      .hbIn       (hbIn),
      .hbEn       (hbEn),
      .settled    (settled),
      .deadActive (deadActive)
   );

   always #5 clk = ~clk;

   // Model state: n counts clock edges since reset release; PWM position is n mod 255,
   // a ramp tick lands on every edge where n is a multiple of 1024.
   int         n;
   logic [3:0] in_d;
   logic [1:0] en_d;
   int         m_mode [2];
   logic [1:0] m_dir  [2];
   int         m_left [2];
   int         m_duty [2];
   int         m_pd   [2];
   logic [1:0] md;
   logic       mok;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         n = 0; in_d = 4'b0; en_d = 2'b0;
         for (int c = 0; c < 2; c++) begin
            m_mode[c] = M_IDLE; m_dir[c] = 2'b00; m_left[c] = 0; m_duty[c] = 0; m_pd[c] = 0;
         end
      end else begin
         n = n + 1;
         for (int c = 0; c < 2; c++) begin
            md  = in_d[2*c +: 2];
            mok = en_d[c] && (md == 2'b10 || md == 2'b01);
            if (!mok) begin
               m_mode[c] = M_IDLE; m_duty[c] = 0;
            end else if (m_mode[c] == M_IDLE) begin
               m_mode[c] = M_RUN; m_dir[c] = md; m_duty[c] = 0;
            end else if (md != m_dir[c]) begin
               m_mode[c] = M_DEAD; m_dir[c] = md; m_left[c] = 255; m_duty[c] = 0;
            end else if (m_mode[c] == M_DEAD) begin
               if (m_left[c] == 0) begin m_mode[c] = M_RUN; m_duty[c] = 0; end
               else m_left[c] = m_left[c] - 1;
            end else if (n % 1024 == 0) begin
               m_duty[c] = (m_duty[c] + 8 > 200) ? 200 : m_duty[c] + 8;
            end
            if (m_mode[c] != M_RUN) m_pd[c] = 0;
            else if (n % 255 == 0) m_pd[c] = m_duty[c];
         end
         in_d = motorIn; en_d = motorEn;
      end
   end

   logic [9:0] exp_v;
   initial forever begin
      @(negedge clk);
      exp_v = '0;
      for (int c = 0; c < 2; c++) begin
         if (m_mode[c] == M_RUN) begin
            exp_v[6+2*c +: 2] = m_dir[c];
            exp_v[4+c]        = ((n % 255) < m_pd[c]);
            exp_v[2+c]        = (m_duty[c] == 200);
         end
         exp_v[c] = (m_mode[c] == M_DEAD);
      end
      tests++;
      if ({hbIn, hbEn, settled, deadActive} !== exp_v) begin
         fails++;
         $display("FAIL model_cycle t=%0t got hbIn/hbEn/settled/dead=%b expected %b",
                  $time, {hbIn, hbEn, settled, deadActive}, exp_v);
      end
      if (hbIn[3:2] == 2'b11 || hbIn[1:0] == 2'b11) ill++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   int k, h0, h1, dcnt;

   initial begin
      rst = 1'b1; motorIn = 4'b0; motorEn = 2'b0;
      repeat (10) @(negedge clk);
      check("reset_outputs", 32'({hbIn, hbEn, settled, deadActive}), 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("release_idle", 32'({hbIn, hbEn, settled, deadActive}), 32'd0);

      // Start both motors forward.
      motorEn = 2'b11; motorIn = 4'b1010;
      @(negedge clk);
      check("one_edge_no_change", 32'(hbIn), 32'd0);
      @(negedge clk);
      check("two_edge_hbin", 32'(hbIn), 32'b1010);
      check("entry_hben_low", 32'(hbEn), 32'd0);
      k = 0;
      while (settled != 2'b11 && k < 30000) begin @(negedge clk); k++; end
      check("settled_reached", 32'(settled), 32'b11);
      check("ramp_25_ticks", 32'(k > 24*1024 && k <= 25*1024), 32'd1);
      repeat (300) @(negedge clk);
      h0 = 0; h1 = 0;
      for (int i = 0; i < 255; i++) begin
         @(negedge clk); h1 += int'(hbEn[1]); h0 += int'(hbEn[0]);
      end
      check("left_high_200_of_255", 32'(h1), 32'd200);
      check("right_high_200_of_255", 32'(h0), 32'd200);

      // Left reversal: dead window of 256 clocks.
      motorIn = 4'b0110;
      @(negedge clk);
      check("rev_one_edge", 32'(hbIn), 32'b1010);
      @(negedge clk);
      check("rev_pins_brake", 32'(hbIn), 32'b0010);
      check("rev_dead_active", 32'(deadActive), 32'b10);
      check("rev_left_en_low", 32'(hbEn[1]), 32'd0);
      dcnt = 0;
      while (deadActive[1] && dcnt < 400) begin dcnt++; @(negedge clk); end
      check("dead_len_256", 32'(dcnt), 32'd256);
      check("after_dead_pins", 32'(hbIn), 32'b0110);
      check("after_dead_settled", 32'(settled), 32'b01);
      check("after_dead_left_en", 32'(hbEn[1]), 32'd0);

      // Mid-ramp disable of the left motor.
      repeat (3000) @(negedge clk);
      check("midramp_not_settled", 32'(settled[1]), 32'd0);
      motorEn = 2'b01;
      @(negedge clk);
      check("dis_one_edge", 32'(hbIn[3:2]), 32'b01);
      @(negedge clk);
      check("dis_pins", 32'(hbIn), 32'b0010);
      check("dis_en", 32'(hbEn[1]), 32'd0);
      repeat (20) @(negedge clk);
      motorEn = 2'b11;
      repeat (2) @(negedge clk);
      check("reen_pins", 32'(hbIn), 32'b0110);
      h1 = 0;
      for (int i = 0; i < 255; i++) begin @(negedge clk); h1 += int'(hbEn[1]); end
      check("reen_duty_from_zero", 32'(h1 <= 8), 32'd1);

      // Right channel given the illegal stop code 11.
      motorIn = 4'b0111;
      repeat (2) @(negedge clk);
      check("stop11_pins", 32'(hbIn), 32'b0100);
      check("stop11_en", 32'(hbEn[0]), 32'd0);
      check("stop11_settled", 32'(settled[0]), 32'd0);

      // Reset in the middle of a dead window.
      motorIn = 4'b0110;
      repeat (50) @(negedge clk);
      motorIn = 4'b1010;
      repeat (102) @(negedge clk);
      check("mid_dead", 32'(deadActive), 32'b10);
      #2 rst = 1'b1;
      #1 check("async_reset", 32'({hbIn, hbEn, settled, deadActive}), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("post_reset_run", 32'(hbIn), 32'b1010);
      check("post_reset_no_dead", 32'(deadActive), 32'd0);
      check("post_reset_en_low", 32'(hbEn), 32'd0);
      repeat (300) @(negedge clk);
      check("no_illegal_11", 32'(ill), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
